// File: rtl/polar_ctrl_pkg.sv
// Shared top-level state codes, default bus widths and the output-side FSM encoding
// for the polar decoder control blocks.
package polar_ctrl_pkg;

  localparam int unsigned DEF_STATE_WIDTH = 10;
  localparam int unsigned DEF_ADDR_WIDTH  = 10;
  localparam int unsigned DEF_DATA_WIDTH  = 8;

  localparam logic [DEF_STATE_WIDTH-1:0] INPUT_STATE  = 10'd4;
  localparam logic [DEF_STATE_WIDTH-1:0] OUTPUT_STATE = 10'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } out_fsm_e;

  // Smallest power of two that is >= n.
  function automatic int unsigned pow2_ceil(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int i = 0; i < 31; i++) begin
      if (p < n) p = p << 1;
    end
    return p;
  endfunction

endpackage

// File: rtl/output_controller_if.sv
// AXI4-Stream master bundle of the output controller.
// OUTPUT_CONTROLLER_FRAME_ID_EN adds the 16-bit tuser frame counter.
interface output_controller_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
`ifdef OUTPUT_CONTROLLER_FRAME_ID_EN
  logic [15:0]           tuser;

  modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);
`else
  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
`endif
endinterface

// File: rtl/output_sync_fifo.sv
// Power-of-two synchronous FIFO with occupancy count and a one-cycle flush.
module output_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic                   pop,
  output logic [DATA_WIDTH-1:0]  rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so push on full is legal alongside it.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  overflow_a: assert property (@(posedge clk) disable iff (reset)
    !(push && full && !pop && !clear));

endmodule

// File: rtl/output_controller.sv
// Streams one frame from the result BRAM to an AXI4-Stream sink while state==OUTPUT_STATE.
// Define OUTPUT_CONTROLLER_FRAME_ID_EN to add a per-frame counter on maxis.tuser.
module output_controller
  import polar_ctrl_pkg::*;
#(
  parameter int unsigned            OUTPUT_LENGTH = 512,
  parameter int unsigned            ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int unsigned            DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned            STATE_WIDTH   = DEF_STATE_WIDTH,
  parameter logic [STATE_WIDTH-1:0] OUTPUT_STATE  = STATE_WIDTH'(polar_ctrl_pkg::OUTPUT_STATE),
  parameter int unsigned            BRAM_LATENCY  = 2,
  parameter int unsigned            FIFO_DEPTH    = pow2_ceil(BRAM_LATENCY + 2)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [STATE_WIDTH-1:0] state,
  output logic [ADDR_WIDTH-1:0]  addr_to_bram,
  output logic                   enable_to_bram,
  input  logic [DATA_WIDTH-1:0]  data_from_bram,
  output_controller_if.master    maxis,
  output logic                   done,
  output logic                   error
);
  localparam int unsigned           CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(OUTPUT_LENGTH - 1);

  out_fsm_e                st_q, st_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, tx_count_q;
  logic [BRAM_LATENCY-1:0] infl_q;
  logic [CW-1:0]           infl_cnt, fifo_count;
  logic [CW:0]             occupancy;
  logic [DATA_WIDTH-1:0]   fifo_head;
  logic                    fifo_empty, fifo_full, done_q, error_q;
  logic                    abort, rd_en, last_rd, hs, tlast, idle_entry;

  assign abort = ((st_q == READ) || (st_q == DRAIN)) && (state != OUTPUT_STATE);

  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < BRAM_LATENCY; i++) infl_cnt = infl_cnt + CW'(infl_q[i]);
  end

  // Credit: every issued read owns a FIFO slot until it is popped.
  assign occupancy = {1'b0, fifo_count} + {1'b0, infl_cnt};
  assign rd_en     = (st_q == READ) && !fifo_full && (occupancy < (CW + 1)'(FIFO_DEPTH));
  assign last_rd   = rd_en && (rd_addr_q == LAST_IDX);

  assign addr_to_bram   = rd_addr_q;
  assign enable_to_bram = rd_en;
  assign done           = done_q;
  assign error          = error_q;

  assign maxis.tvalid = !fifo_empty;
  assign maxis.tdata  = fifo_empty ? '0 : fifo_head;
  assign tlast        = !fifo_empty && (tx_count_q == LAST_IDX);
  assign maxis.tlast  = tlast;
  assign hs           = !fifo_empty && maxis.tready;

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    if (state == OUTPUT_STATE) st_d = READ;
      READ:    if (abort) st_d = IDLE; else if (last_rd) st_d = DRAIN;
      DRAIN:   if (abort) st_d = IDLE; else if (hs && tlast) st_d = DONE;
      DONE:    if (state != OUTPUT_STATE) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  assign idle_entry = (st_d == IDLE) && (st_q != IDLE);

  output_sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .clear(abort),
    .push (infl_q[BRAM_LATENCY-1]),
    .wdata(data_from_bram),
    .pop  (hs),
    .rdata(fifo_head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q       <= IDLE;
      rd_addr_q  <= '0;
      tx_count_q <= '0;
      infl_q     <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      st_q   <= st_d;
      done_q <= (st_q == DRAIN) && !abort && hs && tlast;
      if (abort) error_q <= 1'b1;
      infl_q <= abort ? '0 : ((infl_q << 1) | BRAM_LATENCY'(rd_en));
      if (idle_entry)  rd_addr_q <= '0;
      else if (rd_en)  rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
      if (idle_entry)  tx_count_q <= '0;
      else if (hs)     tx_count_q <= tx_count_q + ADDR_WIDTH'(1);
    end
  end

`ifdef OUTPUT_CONTROLLER_FRAME_ID_EN
  logic [15:0] frame_id_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       frame_id_q <= '0;
    else if (done_q) frame_id_q <= frame_id_q + 16'd1;
  end

  assign maxis.tuser = frame_id_q;
`endif

endmodule
